// File: rtl/score_unit.sv
// score_unit: tracks the argmax of the output-layer values for each test
// vector, scores it against the external label, and publishes the final
// correct/total counts through a valid/ack handshake.
module score_unit #(
  parameter int N_CLASSES = 10,
  parameter int VAL_W     = 32,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_Cor,
  input  logic             ld_Cor,
  input  logic             done,
  input  logic             out_valid,
  input  logic [IDX_W-1:0] out_idx,
  input  logic [VAL_W-1:0] out_val,
  input  logic [31:0]      test_sel,
  input  logic [IDX_W-1:0] label,
  input  logic             result_ack,
  output logic [31:0]      label_addr,
  output logic [IDX_W-1:0] pred_class,
  output logic [31:0]      correct_count,
  output logic [31:0]      tests_scored,
  output logic             result_valid,
  output logic             seq_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] REPORT  = 2'd2;

  // n_seen must be able to hold N_CLASSES itself (vector complete).
  localparam int CNT_W = $clog2(N_CLASSES + 1);
  localparam logic [CNT_W-1:0] SEEN_FULL = CNT_W'(N_CLASSES);
  // Common width for comparing the incoming index against n_seen.
  localparam int CMP_W = (IDX_W > CNT_W) ? IDX_W : CNT_W;

  logic [1:0]              state_reg, state_next;
  logic [CNT_W-1:0]        n_seen_reg, n_seen_next;
  logic signed [VAL_W-1:0] max_val_reg, max_val_next;
  logic [IDX_W-1:0]        pred_reg, pred_next;
  logic [31:0]             correct_reg, correct_next;
  logic [31:0]             tests_reg, tests_next;
  logic                    valid_reg, valid_next;
  logic                    err_reg, err_next;
  logic [31:0]             label_addr_reg;

  // Helper terms for the scoring and sample-acceptance decisions.
  logic             vector_full;
  logic             label_hit;
  logic [CMP_W-1:0] idx_ext;
  logic [CMP_W-1:0] seen_ext;
  logic             idx_in_order;
  logic             new_max;
  logic [31:0]      correct_inc;
  logic [31:0]      tests_inc;

  assign vector_full  = (n_seen_reg == SEEN_FULL);
  assign label_hit    = vector_full && (pred_reg == label);
  assign idx_ext      = CMP_W'(out_idx);
  assign seen_ext     = CMP_W'(n_seen_reg);
  assign idx_in_order = (idx_ext == seen_ext) && !vector_full;
  // Strictly greater keeps the lower index on ties.
  assign new_max      = $signed(out_val) > max_val_reg;

  // Counters saturate at all-ones rather than wrapping.
  assign correct_inc  = (&correct_reg) ? correct_reg : correct_reg + 32'd1;
  assign tests_inc    = (&tests_reg)   ? tests_reg   : tests_reg   + 32'd1;

  // Next-state logic; priority is rst_Cor > done > ld_Cor > out_valid.
  always_comb begin
    state_next   = state_reg;
    n_seen_next  = n_seen_reg;
    max_val_next = max_val_reg;
    pred_next    = pred_reg;
    correct_next = correct_reg;
    tests_next   = tests_reg;
    valid_next   = valid_reg;
    err_next     = err_reg;

    if (rst_Cor) begin
      state_next   = IDLE;
      n_seen_next  = '0;
      max_val_next = '0;
      pred_next    = '0;
      correct_next = '0;
      tests_next   = '0;
      valid_next   = 1'b0;
      err_next     = 1'b0;
    end else if (state_reg == REPORT) begin
      // Counts are frozen here; a stray score request is a protocol error.
      if (ld_Cor) begin
        err_next = 1'b1;
      end
      if (result_ack) begin
        valid_next = 1'b0;
        state_next = IDLE;
      end
    end else begin
      if (ld_Cor) begin
        // Scores the argmax as it stood before this cycle.
        tests_next = tests_inc;
        if (label_hit) begin
          correct_next = correct_inc;
        end
        if (!vector_full) begin
          err_next = 1'b1;
        end
        // A sample arriving with the score strobe is dropped.
        if (out_valid) begin
          err_next = 1'b1;
        end
        n_seen_next = '0;
        state_next  = IDLE;
      end else if (out_valid && !done) begin
        if (state_reg == IDLE) begin
          if (out_idx == '0) begin
            max_val_next = $signed(out_val);
            pred_next    = '0;
            n_seen_next  = CNT_W'(1);
            state_next   = COLLECT;
          end else begin
            err_next = 1'b1;
          end
        end else begin
          if (idx_in_order) begin
            n_seen_next = n_seen_reg + CNT_W'(1);
            if (new_max) begin
              max_val_next = $signed(out_val);
              pred_next    = out_idx;
            end
          end else begin
            err_next = 1'b1;
          end
        end
      end

      // done is applied after any same-cycle score so the count includes it.
      if (done) begin
        valid_next  = 1'b1;
        n_seen_next = '0;
        state_next  = REPORT;
      end
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      n_seen_reg  <= '0;
      max_val_reg <= '0;
      pred_reg    <= '0;
      correct_reg <= '0;
      tests_reg   <= '0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      n_seen_reg  <= n_seen_next;
      max_val_reg <= max_val_next;
      pred_reg    <= pred_next;
      correct_reg <= correct_next;
      tests_reg   <= tests_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
    end
  end

  // Registered label-memory address; label returns one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      label_addr_reg <= '0;
    end else begin
      label_addr_reg <= test_sel;
    end
  end

  assign label_addr    = label_addr_reg;
  assign pred_class    = pred_reg;
  assign correct_count = correct_reg;
  assign tests_scored  = tests_reg;
  assign result_valid  = valid_reg;
  assign seq_err       = err_reg;

endmodule

// File: tb/tb_score_unit.sv
// Self-checking bench for score_unit: a software argmax model pushes the
// expected score into a queue when ld_Cor is driven; it is popped and
// compared after the scoring edge.
module tb_score_unit;
  localparam int N  = 10;
  localparam int VW = 32;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rst_Cor = 1'b0;
  logic          ld_Cor = 1'b0;
  logic          done = 1'b0;
  logic          out_valid = 1'b0;
  logic [IW-1:0] out_idx = '0;
  logic [VW-1:0] out_val = '0;
  logic [31:0]   test_sel = '0;
  logic [IW-1:0] label = '0;
  logic          result_ack = 1'b0;
  logic [31:0]   label_addr;
  logic [IW-1:0] pred_class;
  logic [31:0]   correct_count;
  logic [31:0]   tests_scored;
  logic          result_valid;
  logic          seq_err;

  score_unit #(.N_CLASSES(N), .VAL_W(VW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .rst_Cor(rst_Cor), .ld_Cor(ld_Cor), .done(done),
    .out_valid(out_valid), .out_idx(out_idx), .out_val(out_val),
    .test_sel(test_sel), .label(label), .result_ack(result_ack),
    .label_addr(label_addr), .pred_class(pred_class),
    .correct_count(correct_count), .tests_scored(tests_scored),
    .result_valid(result_valid), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [IW-1:0] pred;
    logic [31:0]   cc;
    logic [31:0]   ts;
    logic          err;
    logic          rv;
  } exp_t;
  exp_t sb[$];

  // Reference model state.
  int m_max, m_pred, m_seen, m_correct, m_tests;
  bit m_err;

  task automatic model_clear();
    m_max = 0; m_pred = 0; m_seen = 0; m_correct = 0; m_tests = 0; m_err = 0;
  endtask

  // One in-order sample; checks pred_class on the edge after out_valid.
  task automatic send(input int idx, input int val);
    out_valid = 1'b1; out_idx = IW'(idx); out_val = VW'(val);
    @(posedge clk); #1;
    out_valid = 1'b0;
    if (idx == 0) begin
      m_max = val; m_pred = 0; m_seen = 1;
    end else begin
      m_seen++;
      if (val > m_max) begin m_max = val; m_pred = idx; end
    end
    checks++;
    if (pred_class !== IW'(m_pred)) begin
      errors++; $display("FAIL pred_update idx=%0d got %0d exp %0d", idx, pred_class, m_pred);
    end
  endtask

  task automatic send_vec(input int vals[N], input int n);
    for (int i = 0; i < n; i++) send(i, vals[i]);
  endtask

  // Score with optional same-cycle done and same-cycle sample.
  task automatic score(input int lbl, input bit with_done, input bit with_ov, input string tag);
    exp_t e, g;
    m_tests++;
    if (m_seen == N) begin
      if (m_pred == lbl) m_correct++;
    end else m_err = 1;
    if (with_ov) m_err = 1;
    m_seen = 0;
    e.pred = IW'(m_pred); e.cc = 32'(m_correct); e.ts = 32'(m_tests);
    e.err = m_err; e.rv = with_done;
    sb.push_back(e);
    label = IW'(lbl); ld_Cor = 1'b1; done = with_done;
    out_valid = with_ov; out_idx = '0; out_val = 32'd5000;
    @(posedge clk); #1;
    ld_Cor = 1'b0; done = 1'b0; out_valid = 1'b0;
    g = sb.pop_front();
    checks += 5;
    if (pred_class !== g.pred) begin errors++; $display("FAIL %s pred got %0d exp %0d", tag, pred_class, g.pred); end
    if (correct_count !== g.cc) begin errors++; $display("FAIL %s correct got %0d exp %0d", tag, correct_count, g.cc); end
    if (tests_scored !== g.ts) begin errors++; $display("FAIL %s tests got %0d exp %0d", tag, tests_scored, g.ts); end
    if (seq_err !== g.err) begin errors++; $display("FAIL %s seq_err got %0d exp %0d", tag, seq_err, g.err); end
    if (result_valid !== g.rv) begin errors++; $display("FAIL %s result_valid got %0d exp %0d", tag, result_valid, g.rv); end
    $display("score %s: pred=%0d cc=%0d ts=%0d err=%0d", tag, pred_class, correct_count, tests_scored, seq_err);
  endtask

  task automatic do_rst_cor(input bit with_ld);
    rst_Cor = 1'b1; ld_Cor = with_ld;
    @(posedge clk); #1;
    rst_Cor = 1'b0; ld_Cor = 1'b0;
    model_clear();
    checks += 5;
    if (correct_count !== 32'd0) begin errors++; $display("FAIL rst_cor correct got %0d exp 0", correct_count); end
    if (tests_scored !== 32'd0) begin errors++; $display("FAIL rst_cor tests got %0d exp 0", tests_scored); end
    if (seq_err !== 1'b0) begin errors++; $display("FAIL rst_cor seq_err got %0d exp 0", seq_err); end
    if (pred_class !== '0) begin errors++; $display("FAIL rst_cor pred got %0d exp 0", pred_class); end
    if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_cor result_valid got %0d exp 0", result_valid); end
    $display("rst_Cor (ld=%0d): counters cleared", with_ld);
  endtask

  task automatic test_reset();
    #3;
    checks += 6;
    if (label_addr !== 32'd0) begin errors++; $display("FAIL reset label_addr got %0d exp 0", label_addr); end
    if (pred_class !== '0) begin errors++; $display("FAIL reset pred got %0d exp 0", pred_class); end
    if (correct_count !== 32'd0) begin errors++; $display("FAIL reset correct got %0d exp 0", correct_count); end
    if (tests_scored !== 32'd0) begin errors++; $display("FAIL reset tests got %0d exp 0", tests_scored); end
    if (result_valid !== 1'b0) begin errors++; $display("FAIL reset result_valid got %0d exp 0", result_valid); end
    if (seq_err !== 1'b0) begin errors++; $display("FAIL reset seq_err got %0d exp 0", seq_err); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    $display("reset: outputs zero");
  endtask

  task automatic test_vectors();
    int v1[N] = '{5, -3, 9, 2, 0, 1, 7, 9, -1, 4};
    int v2[N] = '{-100, -99, -98, -97, -96, -95, -94, -93, -92, -91};
    send_vec(v1, N);
    score(2, 0, 0, "correct");
    send_vec(v2, N);
    score(0, 0, 0, "wrong_neg");
    send_vec(v1, 7);
    score(2, 0, 0, "short");
    do_rst_cor(0);
  endtask

  task automatic test_back_to_back();
    int v[N] = '{1, 2, 3, 40, 5, 6, 7, 8, 9, 10};
    send_vec(v, N);
    // Sample with the score strobe: pre-update argmax scored, sample dropped.
    score(3, 0, 1, "ld_with_sample");
    do_rst_cor(0);
    // Out-of-order first index in IDLE flags an error.
    out_valid = 1'b1; out_idx = IW'(4); out_val = 32'd77;
    @(posedge clk); #1; out_valid = 1'b0;
    checks += 2;
    if (seq_err !== 1'b1) begin errors++; $display("FAIL idle_bad_idx seq_err got %0d exp 1", seq_err); end
    if (pred_class !== '0) begin errors++; $display("FAIL idle_bad_idx pred got %0d exp 0", pred_class); end
    $display("idle bad idx: seq_err=%0d", seq_err);
    do_rst_cor(0);
  endtask

  task automatic test_full_run();
    int vals[N];
    int lbl;
    logic [IW-1:0] last_pred;
    do_rst_cor(0);
    for (int t = 0; t < 750; t++) begin
      test_sel = 32'(t);
      for (int i = 0; i < N; i++) vals[i] = int'($urandom_range(0, 2000)) - 1000;
      send(0, vals[0]);
      checks++;
      if (label_addr !== 32'(t)) begin errors++; $display("FAIL label_addr got %0d exp %0d", label_addr, t); end
      for (int i = 1; i < N; i++) send(i, vals[i]);
      lbl = (t % 5 != 0) ? m_pred : (m_pred + 1) % N;
      score(lbl, t == 749, 0, (t == 749) ? "last_with_done" : "run");
    end
    last_pred = IW'(m_pred);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks += 3;
      if (result_valid !== 1'b1) begin errors++; $display("FAIL hold rv got %0d exp 1", result_valid); end
      if (correct_count !== 32'd600) begin errors++; $display("FAIL hold correct got %0d exp 600", correct_count); end
      if (tests_scored !== 32'd750) begin errors++; $display("FAIL hold tests got %0d exp 750", tests_scored); end
    end
    $display("report: cc=%0d ts=%0d rv=%0d", correct_count, tests_scored, result_valid);
    // REPORT ignores samples; ld_Cor only raises seq_err.
    out_valid = 1'b1; out_idx = '0; out_val = 32'd9999;
    @(posedge clk); #1; out_valid = 1'b0;
    checks++;
    if (pred_class !== last_pred) begin errors++; $display("FAIL report_sample pred got %0d exp %0d", pred_class, last_pred); end
    ld_Cor = 1'b1;
    @(posedge clk); #1; ld_Cor = 1'b0;
    checks += 2;
    if (seq_err !== 1'b1) begin errors++; $display("FAIL report_ld seq_err got %0d exp 1", seq_err); end
    if (tests_scored !== 32'd750) begin errors++; $display("FAIL report_ld tests got %0d exp 750", tests_scored); end
    m_err = 1;
    result_ack = 1'b1;
    @(posedge clk); #1; result_ack = 1'b0;
    checks += 3;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL ack rv got %0d exp 0", result_valid); end
    if (correct_count !== 32'd600) begin errors++; $display("FAIL ack correct got %0d exp 600", correct_count); end
    if (tests_scored !== 32'd750) begin errors++; $display("FAIL ack tests got %0d exp 750", tests_scored); end
    $display("ack: rv=%0d cc=%0d ts=%0d", result_valid, correct_count, tests_scored);
    // Ack with result_valid low does nothing.
    result_ack = 1'b1;
    @(posedge clk); #1; result_ack = 1'b0;
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL idle_ack rv got %0d exp 0", result_valid); end
    // Back in IDLE, scoring resumes from the kept counts.
    for (int i = 0; i < N; i++) send(i, (i == 6) ? 50 : i);
    score(6, 0, 0, "after_ack");
    do_rst_cor(1);
  endtask

  task automatic test_async_reset();
    int v[N] = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    send(0, 1); send(1, 2); send(2, 3); send(3, 30); send(4, 4);
    test_sel = 32'd123;
    #2 rst = 1'b1;
    #1;
    checks += 6;
    if (label_addr !== 32'd0) begin errors++; $display("FAIL async label_addr got %0d exp 0", label_addr); end
    if (pred_class !== '0) begin errors++; $display("FAIL async pred got %0d exp 0", pred_class); end
    if (correct_count !== 32'd0) begin errors++; $display("FAIL async correct got %0d exp 0", correct_count); end
    if (tests_scored !== 32'd0) begin errors++; $display("FAIL async tests got %0d exp 0", tests_scored); end
    if (result_valid !== 1'b0) begin errors++; $display("FAIL async rv got %0d exp 0", result_valid); end
    if (seq_err !== 1'b0) begin errors++; $display("FAIL async seq_err got %0d exp 0", seq_err); end
    $display("async reset mid-collect: outputs zero");
    @(posedge clk); #1 rst = 1'b0;
    model_clear();
    send_vec(v, N);
    score(5, 0, 0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_full_run();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_unit.md
# score_unit

Scoring unit for the NN inference datapath. It receives the output-layer accumulator values as they are produced, tracks the argmax class for the current test vector, and compares it against the label on `ld_Cor`. It keeps the correct-prediction count and presents the final score on `done` through a valid/ack handshake. It is driven by the controller's `ld_Cor`, `rst_Cor` and `done` strobes and by `test_sel`.

## Interface
- `N_CLASSES`, default 10: output neurons per test vector.
- `VAL_W`, default 32: width of the signed output accumulator value.
- `IDX_W`, default 5: width of the class index and label.
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `rst_Cor`, input, 1: clear score and scoring state (synchronous strobe).
- `ld_Cor`, input, 1: score the current test vector.
- `done`, input, 1: end of test set; publish the result.
- `out_valid`, input, 1: `out_val` and `out_idx` are valid this cycle.
- `out_idx`, input, IDX_W: output-neuron index, expected 0..N_CLASSES-1 in order.
- `out_val`, input, VAL_W: signed two's-complement output-neuron value.
- `test_sel`, input, 32: index of the current test vector; passed through as `label_addr`.
- `label`, input, IDX_W: label read from external label memory, valid the cycle after `label_addr` changes.
- `result_ack`, input, 1: consumer accepted the result.
- `label_addr`, output, 32: registered copy of `test_sel`.
- `pred_class`, output, IDX_W: current argmax index.
- `correct_count`, output, 32: running correct-prediction count.
- `tests_scored`, output, 32: number of `ld_Cor` events accepted.
- `result_valid`, output, 1: final result held on `correct_count` and `tests_scored`.
- `seq_err`, output, 1: sticky protocol-error flag.

## Operation
- **States:** IDLE (0), COLLECT (1), REPORT (2).
- **IDLE**
  - `out_valid` with `out_idx`==0: load `max_val`=`out_val`, `pred_class`=0, `n_seen`=1, go to COLLECT.
  - `out_valid` with `out_idx`!=0: set `seq_err`, ignore the value.
- **COLLECT, on `out_valid`**
  - If `out_idx`!=`n_seen` or `n_seen`==N_CLASSES: set `seq_err`, ignore the value.
  - Otherwise increment `n_seen`. If `out_val` > `max_val` (signed, strict), update `max_val` and `pred_class`. Ties keep the lower index.
- **`ld_Cor` in IDLE or COLLECT**
  - Increment `tests_scored`.
  - If `n_seen`==N_CLASSES and `pred_class`==`label`: increment `correct_count`.
  - If `n_seen`!=N_CLASSES: set `seq_err` and do not increment `correct_count`.
  - Clear `n_seen` and go to IDLE.
- **`done` in IDLE or COLLECT:** set `result_valid`, go to REPORT. `correct_count` and `tests_scored` freeze.
- **REPORT**
  - `out_valid` and `ld_Cor` are ignored; `ld_Cor` sets `seq_err`.
  - `result_ack` clears `result_valid` and returns to IDLE. Counts are kept until `rst_Cor`.
- **`rst_Cor` in any state:** clear both counters, `n_seen`, `pred_class`, `max_val`, `seq_err` and `result_valid`; go to IDLE.
- **Counters:** saturate at 2^32-1 and do not wrap.

## Timing
- **Reset values:** every output is 0 and the state is IDLE.
- **Precedence in one cycle:** `rst_Cor` > `done` > `ld_Cor` > `out_valid`.
  - `ld_Cor` and `out_valid` together: `ld_Cor` scores the pre-update argmax. The concurrent sample is dropped and `seq_err` is set.
  - `done` and `ld_Cor` together: `ld_Cor` is scored first, then REPORT is entered. The count includes this test.
- **Latencies**
  - `pred_class` updates on the edge after `out_valid`.
  - `correct_count` and `tests_scored` update on the edge after `ld_Cor`.
  - `result_valid` rises on the edge after `done`.
- **Label timing:** `label_addr` follows `test_sel` with 1-cycle latency. `label` is sampled in the `ld_Cor` cycle and must be stable by then, i.e. at least 2 cycles after the `test_sel` change. The controller satisfies this with its ≥3-cycle hidden/output phase.
- **Handshake:** `result_valid` stays high until the cycle `result_ack` is sampled high and falls on that edge. A `result_ack` received while `result_valid` is low has no effect.
- **Reset mid-operation:** `rst` asserted in any state forces all outputs to 0 asynchronously. No partial test is scored.

## Test plan
- **Correct prediction:** reset; stream values 5, -3, 9, 2, 0, 1, 7, 9, -1, 4 for idx 0..9; `label`=2; pulse `ld_Cor` -> `pred_class`=2 (tie at idx 7 keeps 2), `correct_count`=1, `tests_scored`=1, `seq_err`=0.
- **Wrong prediction, all negative:** stream values -100..-91 for idx 0..9; `label`=0; `ld_Cor` -> `pred_class`=9, `correct_count` unchanged, `tests_scored` incremented.
- **Short vector:** stream 7 values, then `ld_Cor` -> `seq_err`=1, `correct_count` unchanged, `tests_scored`+1. Then `rst_Cor` -> all cleared.
- **Full run:** 750 vectors with 600 matching labels, then `done` -> `result_valid`=1 with `correct_count`=600 and `tests_scored`=750. Both hold 5 cycles with no ack. `result_ack` -> `result_valid`=0 next edge, counts unchanged.
- **Same-cycle events:** `ld_Cor`+`done` on the 750th vector -> count includes it and state is REPORT. `ld_Cor`+`rst_Cor` -> counters 0.
- **Async reset:** assert `rst` mid-COLLECT (idx 4) -> all outputs 0 immediately. After release, a full 10-value vector scores normally.
